// File: rtl/imem_arbiter_if.sv
// Bundle of signals around the instruction-memory arbiter: fetch port, loader port and memory port.
// The arbiter takes the slave side; requesters and the memory array together form the master side.
interface imem_arbiter_if;
    logic        FetchReq;
    logic [31:0] FetchAddr;
    logic        FetchGnt;
    logic        FetchRspValid;
    logic [31:0] FetchRspData;
    logic        FetchRspErr;

    logic        LoadReq;
    logic        LoadWe;
    logic [31:0] LoadAddr;
    logic [31:0] LoadWData;
    logic        LoadLock;
    logic        LoadGnt;
    logic        LoadRspValid;
    logic [31:0] LoadRspData;
    logic        LoadRspErr;
    logic        LockActive;

    logic [31:0] MemAddr;
    logic        MemWe;
    logic [31:0] MemWData;
    logic [31:0] MemRData;

    // Handshake: a request is accepted in the cycle where Req and Gnt are both high.
    // A request that sees Gnt=0 must hold Req/Addr/WData stable and retry next cycle.
    // Every accepted request produces exactly one RspValid pulse on the following cycle.
    modport slave (
        input  FetchReq, FetchAddr,
        output FetchGnt, FetchRspValid, FetchRspData, FetchRspErr,
        input  LoadReq, LoadWe, LoadAddr, LoadWData, LoadLock,
        output LoadGnt, LoadRspValid, LoadRspData, LoadRspErr, LockActive,
        output MemAddr, MemWe, MemWData,
        input  MemRData
    );

    modport master (
        output FetchReq, FetchAddr,
        input  FetchGnt, FetchRspValid, FetchRspData, FetchRspErr,
        output LoadReq, LoadWe, LoadAddr, LoadWData, LoadLock,
        input  LoadGnt, LoadRspValid, LoadRspData, LoadRspErr, LockActive,
        input  MemAddr, MemWe, MemWData,
        output MemRData
    );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port arbiter for the instruction memory: fetch has priority, the loader is protected
// from starvation and can lock the memory for bulk loads. Responses come back one cycle later.
module imem_arbiter #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          MAX_STARVE  = 4,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_arbiter_if.slave        bus,
    output logic [0:0]           o_dbg_state,
    output logic [3:0]           o_dbg_starve_cnt
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_starve_cnt;
    logic        r_lock_active;
    logic        r_fetch_rsp_valid;
    logic [31:0] r_fetch_rsp_data;
    logic        r_fetch_rsp_err;
    logic        r_load_rsp_valid;
    logic [31:0] r_load_rsp_data;
    logic        r_load_rsp_err;

    logic w_locked;
    logic w_starved;
    logic w_load_gnt;
    logic w_fetch_gnt;
    logic w_fetch_err;
    logic w_load_err;
    logic w_load_denied;

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(DEPTH_WORDS));
    endfunction

    assign w_locked      = (r_state == ST_LOCKED);
    assign w_starved     = (r_starve_cnt == 4'(MAX_STARVE));
    assign w_load_gnt    = bus.LoadReq & (w_locked | ~bus.FetchReq | w_starved);
    assign w_fetch_gnt   = bus.FetchReq & ~w_load_gnt & ~w_locked;
    assign w_fetch_err   = addr_err(bus.FetchAddr);
    assign w_load_err    = addr_err(bus.LoadAddr);
    assign w_load_denied = ~w_locked & ~bus.LoadLock & bus.LoadReq & ~w_load_gnt;

    assign bus.FetchGnt = w_fetch_gnt;
    assign bus.LoadGnt  = w_load_gnt;

    // Idle cycles present the fetch address so the array read path stays warm for fetch.
    assign bus.MemAddr  = w_load_gnt ? bus.LoadAddr : bus.FetchAddr;
    assign bus.MemWData = w_load_gnt ? bus.LoadWData : 32'h0;
    assign bus.MemWe    = w_load_gnt & bus.LoadWe & ~w_load_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_RUN;
            r_starve_cnt      <= 4'd0;
            r_lock_active     <= 1'b0;
            r_fetch_rsp_valid <= 1'b0;
            r_fetch_rsp_data  <= 32'h0;
            r_fetch_rsp_err   <= 1'b0;
            r_load_rsp_valid  <= 1'b0;
            r_load_rsp_data   <= 32'h0;
            r_load_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN:    if (bus.LoadLock)  r_state <= ST_LOCKED;
                ST_LOCKED: if (!bus.LoadLock) r_state <= ST_RUN;
                default:   r_state <= ST_RUN;
            endcase
            // Both transitions follow the LoadLock level, so the next state is simply LoadLock.
            r_lock_active <= bus.LoadLock;

            if (w_load_denied && !w_starved)
                r_starve_cnt <= r_starve_cnt + 4'd1;
            else if (!w_load_denied)
                r_starve_cnt <= 4'd0;

            r_fetch_rsp_valid <= w_fetch_gnt;
            if (w_fetch_gnt) begin
                r_fetch_rsp_data <= w_fetch_err ? NOP_INSTR : bus.MemRData;
                r_fetch_rsp_err  <= w_fetch_err;
            end

            r_load_rsp_valid <= w_load_gnt;
            if (w_load_gnt) begin
                r_load_rsp_data <= (w_load_err || bus.LoadWe) ? 32'h0 : bus.MemRData;
                r_load_rsp_err  <= w_load_err;
            end
        end
    end

    assign bus.FetchRspValid = r_fetch_rsp_valid;
    assign bus.FetchRspData  = r_fetch_rsp_data;
    assign bus.FetchRspErr   = r_fetch_rsp_err;
    assign bus.LoadRspValid  = r_load_rsp_valid;
    assign bus.LoadRspData   = r_load_rsp_data;
    assign bus.LoadRspErr    = r_load_rsp_err;
    assign bus.LockActive    = r_lock_active;

    assign o_dbg_state      = r_state;
    assign o_dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed vector table, starvation and reset sequences, then random
// traffic against a rule-level reference model with a response scoreboard.
module tb_imem_arbiter;

    localparam int          DEPTH      = 64;
    localparam int          MAX_STARVE = 4;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic clk;
    logic rst;
    logic [0:0] dbg_state;
    logic [3:0] dbg_starve;

    imem_arbiter_if bus ();

    imem_arbiter #(
        .DEPTH_WORDS (DEPTH),
        .MAX_STARVE  (MAX_STARVE),
        .NOP_INSTR   (NOP)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .o_dbg_state      (dbg_state),
        .o_dbg_starve_cnt (dbg_starve)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory array model ----------------
    logic [31:0] mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    assign bus.MemRData = (bus.MemAddr[31:8] == 24'd0) ? mem[bus.MemAddr[7:2]] : 32'hBADB_AD00;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_data;
        else if (bus.MemWe) mem[bus.MemAddr[7:2]] <= bus.MemWData;
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic        freq;
        logic [31:0] faddr;
        logic        lreq;
        logic        lwe;
        logic [31:0] laddr;
        logic [31:0] lwdata;
        logic        llock;
        logic        e_fg;
        logic        e_lg;
        logic        e_we;
        logic        e_lock;
        logic        e_fv;
        logic [31:0] e_fd;
        logic        e_fe;
        logic        e_lv;
        logic [31:0] e_ld;
        logic        e_le;
    } vec_t;

    function automatic vec_t mkv(int freq, logic [31:0] faddr, int lreq, int lwe,
                                 logic [31:0] laddr, logic [31:0] lwdata, int llock,
                                 int e_fg, int e_lg, int e_we, int e_lock,
                                 int e_fv, logic [31:0] e_fd, int e_fe,
                                 int e_lv, logic [31:0] e_ld, int e_le);
        vec_t v;
        v.freq = freq[0];   v.faddr = faddr;   v.lreq = lreq[0];  v.lwe = lwe[0];
        v.laddr = laddr;    v.lwdata = lwdata; v.llock = llock[0];
        v.e_fg = e_fg[0];   v.e_lg = e_lg[0];  v.e_we = e_we[0];  v.e_lock = e_lock[0];
        v.e_fv = e_fv[0];   v.e_fd = e_fd;     v.e_fe = e_fe[0];
        v.e_lv = e_lv[0];   v.e_ld = e_ld;     v.e_le = e_le[0];
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] exp_fq[$];
    logic [32:0] exp_lq[$];
    logic [32:0] last_f;
    logic [32:0] last_l;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, check the combinational side, then the registered side.
    task automatic apply(input vec_t v);
        bus.FetchReq  = v.freq;
        bus.FetchAddr = v.faddr;
        bus.LoadReq   = v.lreq;
        bus.LoadWe    = v.lwe;
        bus.LoadAddr  = v.laddr;
        bus.LoadWData = v.lwdata;
        bus.LoadLock  = v.llock;
        #2;
        check1("fetch_gnt", bus.FetchGnt, v.e_fg);
        check1("load_gnt", bus.LoadGnt, v.e_lg);
        check1("mem_we", bus.MemWe, v.e_we);
        check32("mem_addr", bus.MemAddr, v.e_lg ? v.laddr : v.faddr);
        if (v.e_we) begin
            check32("mem_wdata", bus.MemWData, v.lwdata);
            ref_mem[v.laddr[7:2]] = v.lwdata;
        end
        if (v.e_fv) exp_fq.push_back({v.e_fe, v.e_fd});
        if (v.e_lv) exp_lq.push_back({v.e_le, v.e_ld});
        @(posedge clk);
        #1;
        check1("fetch_rsp_valid", bus.FetchRspValid, v.e_fv);
        check1("load_rsp_valid", bus.LoadRspValid, v.e_lv);
        check1("lock_active", bus.LockActive, v.e_lock);
        if (v.e_fv && exp_fq.size() > 0) last_f = exp_fq.pop_front();
        if (v.e_lv && exp_lq.size() > 0) last_l = exp_lq.pop_front();
        check32("fetch_rsp_data", bus.FetchRspData, last_f[31:0]);
        check1("fetch_rsp_err", bus.FetchRspErr, last_f[32]);
        check32("load_rsp_data", bus.LoadRspData, last_l[31:0]);
        check1("load_rsp_err", bus.LoadRspErr, last_l[32]);
    endtask

    // ---------------- reference model ----------------
    bit m_locked;
    int m_starve;

    function automatic bit bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    task automatic model_fill(inout vec_t v);
        bit fe, le, fg, lg;
        fe = bad_addr(v.faddr);
        le = bad_addr(v.laddr);
        if (m_locked) begin
            fg = 1'b0;
            lg = v.lreq;
        end else begin
            lg = v.lreq && (!v.freq || m_starve == MAX_STARVE);
            fg = v.freq && !lg;
        end
        v.e_fg   = fg;
        v.e_lg   = lg;
        v.e_we   = lg && v.lwe && !le;
        v.e_lock = v.llock;
        v.e_fv   = fg;
        v.e_fe   = fe;
        v.e_fd   = fe ? NOP : ref_mem[v.faddr[7:2]];
        v.e_lv   = lg;
        v.e_le   = le;
        v.e_ld   = (le || v.lwe) ? 32'h0 : ref_mem[v.laddr[7:2]];
        if (!m_locked && !v.llock && v.lreq && !lg)
            m_starve = (m_starve < MAX_STARVE) ? m_starve + 1 : MAX_STARVE;
        else
            m_starve = 0;
        m_locked = v.llock;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return $urandom;
        return {24'd0, 6'($urandom_range(0, 63)), 2'b00};
    endfunction

    // ---------------- stimulus ----------------
    vec_t tbl [14];
    vec_t v;
    vec_t prev;
    logic cur_lock;

    initial begin
        rst = 1'b1;
        pl_en = 1'b0; pl_idx = 6'd0; pl_data = 32'h0;
        bus.FetchReq = 1'b0; bus.FetchAddr = 32'h0;
        bus.LoadReq = 1'b0; bus.LoadWe = 1'b0; bus.LoadAddr = 32'h0;
        bus.LoadWData = 32'h0; bus.LoadLock = 1'b0;
        last_f = 33'h0; last_l = 33'h0;
        @(posedge clk); #1;

        // Preload word i with (i+1)*0x11 while held in reset: 0x11, 0x22, 0x33, ...
        for (int i = 0; i < DEPTH; i++) begin
            pl_en = 1'b1; pl_idx = 6'(i); pl_data = 32'(i + 1) * 32'h11;
            ref_mem[i] = 32'(i + 1) * 32'h11;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;

        check1("rst_fetch_valid", bus.FetchRspValid, 1'b0);
        check1("rst_load_valid", bus.LoadRspValid, 1'b0);
        check1("rst_lock_active", bus.LockActive, 1'b0);
        check32("rst_fetch_data", bus.FetchRspData, 32'h0);
        check1("rst_load_err", bus.LoadRspErr, 1'b0);
        check32("rst_starve", 32'(dbg_starve), 32'h0);
        rst = 1'b0;

        //            freq faddr     lreq lwe laddr      lwdata       lock fg lg we lk fv fd            fe lv ld     le
        tbl[0]  = mkv(1, 32'h00,     0, 0, 32'h0,      32'h0,        0,   1, 0, 0, 0, 1, 32'h11,       0, 0, 32'h0, 0);
        tbl[1]  = mkv(1, 32'h04,     0, 0, 32'h0,      32'h0,        0,   1, 0, 0, 0, 1, 32'h22,       0, 0, 32'h0, 0);
        tbl[2]  = mkv(1, 32'h08,     0, 0, 32'h0,      32'h0,        0,   1, 0, 0, 0, 1, 32'h33,       0, 0, 32'h0, 0);
        tbl[3]  = mkv(1, 32'h02,     0, 0, 32'h0,      32'h0,        0,   1, 0, 0, 0, 1, NOP,          1, 0, 32'h0, 0);
        tbl[4]  = mkv(1, 32'h100,    0, 0, 32'h0,      32'h0,        0,   1, 0, 0, 0, 1, NOP,          1, 0, 32'h0, 0);
        tbl[5]  = mkv(0, 32'h00,     1, 1, 32'h100,    32'h1234,     0,   0, 1, 0, 0, 0, 32'h0,        0, 1, 32'h0, 1);
        tbl[6]  = mkv(0, 32'h00,     1, 0, 32'h08,     32'h0,        0,   0, 1, 0, 0, 0, 32'h0,        0, 1, 32'h33, 0);
        tbl[7]  = mkv(0, 32'h00,     1, 1, 32'h1C,     32'hCAFE0001, 0,   0, 1, 1, 0, 0, 32'h0,        0, 1, 32'h0, 0);
        tbl[8]  = mkv(1, 32'h1C,     0, 0, 32'h0,      32'h0,        0,   1, 0, 0, 0, 1, 32'hCAFE0001, 0, 0, 32'h0, 0);
        tbl[9]  = mkv(0, 32'h00,     0, 0, 32'h0,      32'h0,        0,   0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0, 0);
        tbl[10] = mkv(1, 32'h00,     0, 0, 32'h0,      32'h0,        1,   1, 0, 0, 1, 1, 32'h11,       0, 0, 32'h0, 0);
        tbl[11] = mkv(1, 32'h10,     1, 1, 32'h10,     32'hDEADBEEF, 1,   0, 1, 1, 1, 0, 32'h0,        0, 1, 32'h0, 0);
        tbl[12] = mkv(1, 32'h10,     0, 0, 32'h0,      32'h0,        0,   0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0, 0);
        tbl[13] = mkv(1, 32'h10,     0, 0, 32'h0,      32'h0,        0,   1, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0, 0);
        for (int i = 0; i < 14; i++) apply(tbl[i]);

        // Starvation: both requesting, loader wins on every 5th cycle.
        for (int i = 0; i < 15; i++) begin
            v = mkv(1, 32'h00, 1, 0, 32'h04, 32'h0, 0,
                    (i % 5 != 4) ? 1 : 0, (i % 5 == 4) ? 1 : 0, 0, 0,
                    (i % 5 != 4) ? 1 : 0, 32'h11, 0,
                    (i % 5 == 4) ? 1 : 0, 32'h22, 0);
            apply(v);
        end

        // Reset while LOCKED with a loader grant in flight.
        apply(mkv(0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 1, 0, 32'h0, 0, 0, 32'h0, 0));
        bus.FetchReq = 1'b1; bus.FetchAddr = 32'h08;
        bus.LoadReq = 1'b1; bus.LoadWe = 1'b0; bus.LoadAddr = 32'h04; bus.LoadLock = 1'b1;
        rst = 1'b1;
        #2;
        check1("locked_load_gnt", bus.LoadGnt, 1'b1);
        check1("locked_fetch_gnt", bus.FetchGnt, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        check1("rst_mid_lock", bus.LockActive, 1'b0);
        check1("rst_mid_load_valid", bus.LoadRspValid, 1'b0);
        check1("rst_mid_fetch_valid", bus.FetchRspValid, 1'b0);
        check32("rst_mid_load_data", bus.LoadRspData, 32'h0);
        check32("rst_mid_starve", 32'(dbg_starve), 32'h0);
        check32("rst_mid_state", 32'(dbg_state), 32'h0);
        exp_fq.delete(); exp_lq.delete();
        last_f = 33'h0; last_l = 33'h0;
        m_locked = 1'b0; m_starve = 0;
        v = mkv(1, 32'h08, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
        model_fill(v);
        apply(v);

        // Random traffic against the reference model; denied requesters hold their request.
        prev = v;
        cur_lock = 1'b0;
        for (int i = 0; i < 400; i++) begin
            v = prev;
            if (!(prev.freq && !prev.e_fg)) begin
                v.freq  = ($urandom_range(0, 3) != 0);
                v.faddr = rand_addr();
            end
            if (!(prev.lreq && !prev.e_lg)) begin
                v.lreq   = ($urandom_range(0, 1) == 1);
                v.lwe    = ($urandom_range(0, 1) == 1);
                v.laddr  = rand_addr();
                v.lwdata = $urandom;
            end
            if ($urandom_range(0, 11) == 0) cur_lock = ~cur_lock;
            v.llock = cur_lock;
            model_fill(v);
            apply(v);
            prev = v;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
